// File: rtl/display_button_scanner.sv
// display_button_scanner
// Continuously scans a 74HC165-style parallel-in/serial-out button chain.
// A tick divider paces the external shift clock; an FSM pulses the parallel
// load, samples each serial bit MSB-first and then clocks the chain on.
// At the end of each complete scan it publishes a registered,
// polarity-corrected button word together with one-cycle valid and
// changed strobes.

module display_button_scanner #(
  parameter int CLK_DIV  = 8,   // CLOCK_50 cycles per shift-clock half-period, >= 4
  parameter int N_BITS   = 16,  // length of the external shift-register chain
  parameter int SCAN_GAP = 16,  // idle ticks between scans
  parameter int INVERT   = 1    // 1 = buttons are active-low on the wire
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  output logic              SHIFT_CLKIN,
  output logic              SHIFT_LOAD,
  input  logic              SHIFT_OUT,
  output logic [N_BITS-1:0] buttons,
  output logic              valid,
  output logic              changed
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int GAP_W = (SCAN_GAP > 0) ? $clog2(SCAN_GAP + 1) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(N_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SCAN_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HOLD,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_DONE
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [1:0]         sync_q;
  logic [N_BITS-1:0]  capture;
  logic [N_BITS-1:0]  scan_word;
  logic               tick;

  // One tick per CLK_DIV cycles; every FSM step except DONE waits on it.
  assign tick = (div_cnt == DIV_LAST);

  // Captured bits are corrected for wire polarity before publication.
  assign scan_word = (INVERT != 0) ? ~capture : capture;

  // Tick divider: free-running modulo CLK_DIV, realigned to 0 in the DONE
  // cycle so that every scan period is exactly one cycle longer than the
  // tick-aligned part of the scan.
  // NOTE: clocked state is always updated with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (state == S_DONE || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Two-flop synchroniser for the asynchronous serial data line.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], SHIFT_OUT};
    end
  end

  // Scan sequencer with registered pin drives and registered results. The
  // published word and strobes are loaded on the edge that enters DONE, so
  // they are visible for exactly the one cycle spent in DONE.
  // NOTE: the capture register is reset along with everything else; it is
  // a plain flop bank rather than a memory, so the reset costs nothing and
  // keeps simulation free of X before the first scan completes.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      gap_cnt     <= '0;
      bit_cnt     <= '0;
      capture     <= '0;
      SHIFT_CLKIN <= 1'b0;
      SHIFT_LOAD  <= 1'b1;
      buttons     <= '0;
      valid       <= 1'b0;
      changed     <= 1'b0;
    end else begin
      valid   <= 1'b0;
      changed <= 1'b0;
      case (state)
        S_IDLE: begin
          SHIFT_LOAD  <= 1'b1;
          SHIFT_CLKIN <= 1'b0;
          if (SCAN_GAP == 0) begin
            state      <= S_LOAD;
            SHIFT_LOAD <= 1'b0;
          end else if (tick) begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt    <= '0;
              state      <= S_LOAD;
              SHIFT_LOAD <= 1'b0;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
        end

        S_LOAD: begin
          if (tick) begin
            SHIFT_LOAD <= 1'b1;
            state      <= S_HOLD;
          end
        end

        S_HOLD: begin
          if (tick) begin
            bit_cnt <= '0;
            state   <= S_SHIFT_LO;
          end
        end

        S_SHIFT_LO: begin
          // The chain presents its next bit before the rising edge, so the
          // sample is taken at the end of the low phase.
          if (tick) begin
            capture[BIT_LAST - bit_cnt] <= sync_q[1];
            SHIFT_CLKIN                 <= 1'b1;
            state                       <= S_SHIFT_HI;
          end
        end

        S_SHIFT_HI: begin
          if (tick) begin
            SHIFT_CLKIN <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              buttons <= scan_word;
              valid   <= 1'b1;
              changed <= (scan_word != buttons);
              state   <= S_DONE;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              state   <= S_SHIFT_LO;
            end
          end
        end

        S_DONE: begin
          // With no idle gap the next load starts straight away so its low
          // pulse spans a full tick period from the realigned divider.
          if (SCAN_GAP == 0) begin
            state      <= S_LOAD;
            SHIFT_LOAD <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/display_button_scanner.md
Name: display_button_scanner

Overview:
- Reads the display-board button shift register (parallel-in/serial-out, 74HC165-style) through SHIFT_LOAD, SHIFT_CLKIN and SHIFT_OUT.
- Scans continuously and presents a registered, polarity-corrected button vector plus per-scan valid and changed strobes.
- Sits in toplevel between the display-board GPIO pins and user logic that consumes button state, for example LEDR or HEX drivers.

Parameters:
CLK_DIV, 8, CLOCK_50 cycles per shift-clock half-period (tick interval); must be >= 4
N_BITS, 16, number of bits in the external shift-register chain
SCAN_GAP, 16, idle ticks between scans
INVERT, 1, 1 = buttons are active-low on the wire and are inverted before output; 0 = pass raw

Ports:
CLOCK_50  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-high reset
SHIFT_CLKIN  output  1  shift clock to external register; registered
SHIFT_LOAD  output  1  active-low parallel load to external register; registered
SHIFT_OUT  input  1  serial data from external register
buttons  output  N_BITS  last completed scan; bit N_BITS-1 = first serial bit
valid  output  1  one-cycle pulse when buttons updates
changed  output  1  one-cycle pulse, coincident with valid, when the new buttons value differs from the previous one

Behaviour:
- Reset (async assert, all state):
  - SHIFT_CLKIN=0, SHIFT_LOAD=1, buttons=0, valid=0, changed=0.
  - FSM=IDLE, divider=0, bit counter=0, synchroniser flops=0.
- Tick generator:
  - Divider counts 0..CLK_DIV-1 and wraps.
  - tick is asserted in the cycle the divider equals CLK_DIV-1.
  - Divider is forced to 0 in the DONE cycle.
- SHIFT_OUT passes through a 2-flop synchroniser before sampling (latency 2 cycles; covered by CLK_DIV >= 4).
- FSM (transitions occur on tick, except DONE):
  - IDLE: LOAD=1, CLKIN=0. Count SCAN_GAP ticks, then go to LOAD.
  - LOAD: SHIFT_LOAD=0 for exactly 1 tick period (CLK_DIV cycles), then go to HOLD.
  - HOLD: SHIFT_LOAD=1, CLKIN=0 for 1 tick, then go to SHIFT_LO with bit=0.
  - SHIFT_LO: CLKIN=0. On the tick, sample synchronised SHIFT_OUT into capture register, MSB-first (first sample ends in bit N_BITS-1). Go to SHIFT_HI.
  - SHIFT_HI: CLKIN=1 (rising edge advances the external chain). On the tick, if bit==N_BITS-1 go to DONE; else bit++ and go to SHIFT_LO.
  - DONE (exactly 1 cycle):
    - buttons <= INVERT ? ~capture : capture.
    - valid=1.
    - changed=1 iff the new value != old buttons.
    - Next state IDLE.
- First bit is sampled before any rising edge, because the external chain presents its first bit immediately after load.
- Exactly N_BITS rising edges of SHIFT_CLKIN per scan. Exactly one SHIFT_LOAD low pulse per scan, width CLK_DIV cycles.
- Scan period (valid to valid) = CLK_DIV*(SCAN_GAP+2+2*N_BITS)+1 cycles.
- First valid after reset release: CLK_DIV*(SCAN_GAP+2+2*N_BITS) cycles.
- changed on the first scan after reset compares against the reset value 0.
- buttons is held stable between DONE cycles. A partial capture is never visible.
- Reset mid-scan aborts the scan. Outputs return to reset values immediately, and no valid is issued until a complete new scan finishes.
- Bit counter width is clog2(N_BITS). Divider width is clog2(CLK_DIV). Gap counter width is clog2(SCAN_GAP+1).
- SCAN_GAP=0 is legal: IDLE lasts 0 ticks and passes to LOAD on the cycle after DONE.

Test Plan:
1. CLK_DIV=4, N_BITS=16, SCAN_GAP=2, INVERT=1; bench models a 165 chain loaded with raw 16'hA5C3 -> first valid 144 cycles after reset release; buttons=16'h5A3C; changed=1.
2. Same data held -> next valid exactly 145 cycles later; buttons=16'h5A3C; changed=0. Across the scan, count 16 SHIFT_CLKIN rising edges and a single SHIFT_LOAD low pulse of 4 cycles, with SHIFT_CLKIN=0 throughout the load.
3. Change raw bit 0 to 0 (16'hA5C2) between scans -> next valid shows buttons=16'h5A3D, changed=1. The following scan shows changed=0.
4. Assert reset during SHIFT_HI of bit 7 -> same cycle: SHIFT_CLKIN=0, SHIFT_LOAD=1, buttons=0, valid=0. After release, the next valid arrives only after 144 cycles and carries the full correct word.
5. INVERT=0, N_BITS=8, CLK_DIV=5, SCAN_GAP=0, raw 8'h81 -> buttons=8'h81. Valid period = 5*(0+2+16)+1 = 91 cycles.
6. Raw toggles between 16'h0000 and 16'hFFFF every scan, INVERT=1 -> buttons alternates 16'hFFFF/16'h0000 with changed=1 on every valid. buttons is never observed at an intermediate value between valids.
